cp0_exc_unit: RTL and testbench
===============================

Name: cp0_exc_unit

Overview:
- Coprocessor-0 and exception commit unit; the producer side of the pipeline controller's exception/flush interface.
- Takes committing MEM-stage exception/ERET/MTC0 information and external interrupt lines, and holds the architectural CP0 registers.
- Drives the 33-bit CP0_to_ctrl_bus ({flush_req, new_pc}) and stallreq_for_cp0 into the controller.
- Serves MFC0 reads for the EX stage.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, general exception entry address placed on new_pc.
- CP0_TO_CTRL_WD, 33, width of the controller bus: bit 32 = flush request, bits 31:0 = target PC.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- mem_valid  in  1  MEM stage holds a real (non-bubble) instruction this cycle.
- mem_pc  in  32  PC of the MEM-stage instruction.
- mem_in_ds  in  1  MEM instruction sits in a branch delay slot.
- mem_excp  in  7  flags: [0] AdEL-fetch, [1] RI, [2] Ov, [3] Sys, [4] Bp, [5] AdEL-data, [6] AdES.
- mem_badvaddr  in  32  faulting data address for flags [5]/[6].
- mem_eret  in  1  MEM instruction is ERET.
- mem_mtc0  in  1  MEM instruction is MTC0.
- mem_cp0_addr  in  8  {reg[4:0], sel[2:0]} for MTC0.
- mem_wdata  in  32  MTC0 write data.
- ex_mfc0  in  1  EX instruction is MFC0.
- ex_cp0_addr  in  8  {reg, sel} for MFC0.
- ext_int  in  6  hardware interrupt lines, level-sensitive.
- cp0_rdata  out  32  MFC0 read data (combinational from ex_cp0_addr).
- CP0_to_ctrl_bus  out  33  {flush_req, new_pc} to the controller.
- stallreq_for_cp0  out  1  stall request to the controller.

Behaviour:
- Registers ({reg,sel}) and reset values, all loaded on the clock edge while resetn=0:
  - BadVAddr {8,0} = 0, read-only.
  - Count {9,0} = 0.
  - Compare {11,0} = 0.
  - Status {12,0} = 32'h0040_0000. BEV (bit 22) reads 1. Writable bits: IM[15:8], EXL[1], IE[0].
  - Cause {13,0} = 0. BD[31], TI[30], IP[7:2] and ExcCode[6:2] are hardware-owned; IP[1:0] is software-writable.
  - EPC {14,0} = 0.
  - Unimplemented addresses read 0 and ignore writes.
- Outputs while resetn=0: CP0_to_ctrl_bus = 0, stallreq_for_cp0 = 0.
- Count: an internal toggle bit flips every cycle; Count increments when the toggle is 1 (once per 2 cycles), wrapping 32'hFFFF_FFFF -> 0.
- TI:
  - Set on the edge after Count == Compare (with Compare != 0 or after any write).
  - Cleared by an MTC0 to Compare.
  - MTC0 Count/Compare wins over the same-cycle increment.
- Cause.IP[7:2] = {ext_int[5] | TI, ext_int[4:0]}, sampled every cycle.
- Interrupt pending: Status.IE=1, Status.EXL=0, and (Cause.IP & Status.IM) != 0. It is taken only on an instruction with mem_valid=1.
- Exception priority (highest first): Int (0x00) > AdEL-fetch (0x04) > RI (0x0a) > Ov (0x0c) > Sys (0x08) > Bp (0x09) > AdEL-data (0x04) > AdES (0x05).
- Flush output (combinational, same cycle the instruction is in MEM):
  - Exception taken: bus = {1, EXC_VECTOR}.
  - Else mem_valid & mem_eret: bus = {1, EPC}.
  - Else bus = 0.
- Commit on the edge when an exception is taken:
  - ExcCode <= code.
  - If Status.EXL was 0: EPC <= mem_in_ds ? mem_pc-4 : mem_pc, and Cause.BD <= mem_in_ds.
  - If Status.EXL was 1: EPC and BD are unchanged.
  - Status.EXL <= 1.
  - BadVAddr <= mem_pc for AdEL-fetch, or mem_badvaddr for data AdEL/AdES; other codes leave it unchanged.
- ERET commit: Status.EXL <= 0; no other state change.
- An excepting instruction suppresses its own MTC0/ERET.
- MTC0 commits on the edge only if mem_valid=1 and no exception is taken.
- Hazard stall: stallreq_for_cp0 = ex_mfc0 & mem_valid & mem_mtc0 & (ex_cp0_addr == mem_cp0_addr). It holds EX for exactly one cycle, until the write is visible. It is forced to 0 in any cycle flush_req=1.

Optional Feature:
- Macro CP0_TIMER_INT_EN.
- Defined: Count/Compare/TI logic as above; IP[7] = ext_int[5] | TI.
- Undefined: Count and Compare read 0 and ignore writes, TI is tied to 0, and IP[7] = ext_int[5].

Test Plan:
- Reset: hold resetn=0 for 2 cycles, then MFC0 {12,0} -> rdata 32'h0040_0000; MFC0 {13,0} -> 0; bus = 0.
- Syscall: mem_valid=1, mem_pc=32'hBFC0_0100, mem_excp=7'b0001000 -> bus = {1, 32'hBFC0_0380} the same cycle; afterwards EPC=32'hBFC0_0100, ExcCode=0x08, EXL=1.
- Delay slot with AdES: mem_in_ds=1, pc=32'hBFC0_0204, mem_excp[6]=1, badvaddr=32'h0000_0003 -> EPC=32'hBFC0_0200, BD=1, BadVAddr=3, ExcCode=0x05.
- ERET: EPC=32'h8000_1000, then mem_eret=1 -> bus = {1, 32'h8000_1000}; EXL=0 next cycle.
- Timer (macro on): MTC0 Status=32'h0000_8001, Compare=10, Count=0 -> TI set after about 20 cycles; next valid MEM instruction flushes to 32'hBFC0_0380 with ExcCode 0. A subsequent MTC0 to Compare clears TI.
- Hazard: MTC0 EPC in MEM with MFC0 {14,0} in EX -> stallreq_for_cp0=1 for 1 cycle; next cycle rdata = the new EPC. The same case with an exception in MEM -> stall 0 and the EPC write suppressed.

Source files
------------

// File: rtl/cp0_exc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_exc_unit
//  Brief    : CP0 register file and exception/ERET commit unit. Drives the
//             {flush_req, new_pc} bus and the MTC0->MFC0 hazard stall.
//             Optional timer (Count/Compare/TI) enabled by CP0_TIMER_INT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module cp0_exc_unit #(
    parameter logic [31:0] EXC_VECTOR     = 32'hBFC0_0380,
    parameter int          CP0_TO_CTRL_WD = 33
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      mem_valid,
    input  logic [31:0]               mem_pc,
    input  logic                      mem_in_ds,
    input  logic [6:0]                mem_excp,
    input  logic [31:0]               mem_badvaddr,
    input  logic                      mem_eret,
    input  logic                      mem_mtc0,
    input  logic [7:0]                mem_cp0_addr,
    input  logic [31:0]               mem_wdata,
    input  logic                      ex_mfc0,
    input  logic [7:0]                ex_cp0_addr,
    input  logic [5:0]                ext_int,
    output logic [31:0]               cp0_rdata,
    output logic [CP0_TO_CTRL_WD-1:0] CP0_to_ctrl_bus,
    output logic                      stallreq_for_cp0
);

    localparam logic [7:0] c_ADDR_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] c_ADDR_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] c_ADDR_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] c_ADDR_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] c_ADDR_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] c_ADDR_EPC      = {5'd14, 3'd0};

    localparam logic [4:0] c_EXC_INT  = 5'h00;
    localparam logic [4:0] c_EXC_ADEL = 5'h04;
    localparam logic [4:0] c_EXC_ADES = 5'h05;
    localparam logic [4:0] c_EXC_SYS  = 5'h08;
    localparam logic [4:0] c_EXC_BP   = 5'h09;
    localparam logic [4:0] c_EXC_RI   = 5'h0a;
    localparam logic [4:0] c_EXC_OV   = 5'h0c;

    logic [31:0] r_badvaddr;
    logic [31:0] r_epc;
    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip_hw;
    logic [1:0]  r_cause_ip_sw;
    logic [4:0]  r_cause_exccode;

    logic        w_ti;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [7:0]  w_cause_ip;
    logic        w_int_pending;
    logic        w_exc_take;
    logic        w_eret_req;
    logic        w_eret_commit;
    logic        w_mtc0_commit;
    logic        w_flush;
    logic [31:0] w_new_pc;
    logic [4:0]  w_exc_code;
    logic        w_bad_load;
    logic [31:0] w_bad_value;

    assign w_cause_ip    = {r_cause_ip_hw, r_cause_ip_sw};
    assign w_int_pending = r_status_ie & ~r_status_exl & (|(w_cause_ip & r_status_im));
    assign w_exc_take    = mem_valid & (w_int_pending | (|mem_excp));
    assign w_eret_req    = mem_valid & mem_eret;
    assign w_eret_commit = w_eret_req & ~w_exc_take;
    assign w_mtc0_commit = mem_valid & mem_mtc0 & ~w_exc_take;

    // Interrupt outranks every synchronous flag; flags follow bit order.
    always_comb begin
        w_exc_code  = c_EXC_INT;
        w_bad_load  = 1'b0;
        w_bad_value = mem_pc;
        if (w_int_pending) begin
            w_exc_code = c_EXC_INT;
        end else if (mem_excp[0]) begin
            w_exc_code = c_EXC_ADEL;
            w_bad_load = 1'b1;
        end else if (mem_excp[1]) begin
            w_exc_code = c_EXC_RI;
        end else if (mem_excp[2]) begin
            w_exc_code = c_EXC_OV;
        end else if (mem_excp[3]) begin
            w_exc_code = c_EXC_SYS;
        end else if (mem_excp[4]) begin
            w_exc_code = c_EXC_BP;
        end else if (mem_excp[5]) begin
            w_exc_code  = c_EXC_ADEL;
            w_bad_load  = 1'b1;
            w_bad_value = mem_badvaddr;
        end else if (mem_excp[6]) begin
            w_exc_code  = c_EXC_ADES;
            w_bad_load  = 1'b1;
            w_bad_value = mem_badvaddr;
        end
    end

`ifdef CP0_TIMER_INT_EN
    logic        r_tick;
    logic        r_cmp_armed;
    logic        r_ti;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        w_wr_count;
    logic        w_wr_compare;

    assign w_wr_count   = w_mtc0_commit & (mem_cp0_addr == c_ADDR_COUNT);
    assign w_wr_compare = w_mtc0_commit & (mem_cp0_addr == c_ADDR_COMPARE);

    // Compare==0 out of reset must not fire until software programs Compare.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tick      <= 1'b0;
            r_cmp_armed <= 1'b0;
            r_ti        <= 1'b0;
            r_count     <= 32'd0;
            r_compare   <= 32'd0;
        end else begin
            r_tick <= ~r_tick;
            if (w_wr_count) begin
                r_count <= mem_wdata;
            end else if (r_tick) begin
                r_count <= r_count + 32'd1;
            end
            if (w_wr_compare) begin
                r_compare   <= mem_wdata;
                r_cmp_armed <= 1'b1;
                r_ti        <= 1'b0;
            end else if ((r_count == r_compare) && ((r_compare != 32'd0) || r_cmp_armed)) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign w_ti      = r_ti;
    assign w_count   = r_count;
    assign w_compare = r_compare;
`else
    assign w_ti      = 1'b0;
    assign w_count   = 32'd0;
    assign w_compare = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_badvaddr      <= 32'd0;
            r_epc           <= 32'd0;
            r_status_im     <= 8'd0;
            r_status_exl    <= 1'b0;
            r_status_ie     <= 1'b0;
            r_cause_bd      <= 1'b0;
            r_cause_ip_hw   <= 6'd0;
            r_cause_ip_sw   <= 2'd0;
            r_cause_exccode <= 5'd0;
        end else begin
            r_cause_ip_hw <= {ext_int[5] | w_ti, ext_int[4:0]};
            if (w_exc_take) begin
                r_cause_exccode <= w_exc_code;
                // A nested exception keeps the EPC/BD of the outer one.
                if (!r_status_exl) begin
                    r_epc      <= mem_in_ds ? (mem_pc - 32'd4) : mem_pc;
                    r_cause_bd <= mem_in_ds;
                end
                r_status_exl <= 1'b1;
                if (w_bad_load) begin
                    r_badvaddr <= w_bad_value;
                end
            end else if (w_eret_commit) begin
                r_status_exl <= 1'b0;
            end else if (w_mtc0_commit) begin
                case (mem_cp0_addr)
                    c_ADDR_STATUS: begin
                        r_status_im  <= mem_wdata[15:8];
                        r_status_exl <= mem_wdata[1];
                        r_status_ie  <= mem_wdata[0];
                    end
                    c_ADDR_CAUSE: r_cause_ip_sw <= mem_wdata[9:8];
                    c_ADDR_EPC:   r_epc         <= mem_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cp0_rdata = 32'd0;
        case (ex_cp0_addr)
            c_ADDR_BADVADDR: cp0_rdata = r_badvaddr;
            c_ADDR_COUNT:    cp0_rdata = w_count;
            c_ADDR_COMPARE:  cp0_rdata = w_compare;
            c_ADDR_STATUS:   cp0_rdata = {9'd0, 1'b1, 6'd0, r_status_im, 6'd0,
                                          r_status_exl, r_status_ie};
            c_ADDR_CAUSE:    cp0_rdata = {r_cause_bd, w_ti, 14'd0, w_cause_ip, 1'b0,
                                          r_cause_exccode, 2'b00};
            c_ADDR_EPC:      cp0_rdata = r_epc;
            default:         cp0_rdata = 32'd0;
        endcase
    end

    assign w_flush  = w_exc_take | w_eret_req;
    assign w_new_pc = w_exc_take ? EXC_VECTOR : (w_eret_req ? r_epc : 32'd0);

    assign CP0_to_ctrl_bus  = resetn ? {w_flush, w_new_pc} : '0;
    assign stallreq_for_cp0 = resetn & ex_mfc0 & mem_valid & mem_mtc0
                              & (ex_cp0_addr == mem_cp0_addr) & ~w_flush;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cp0_exc_unit
//  Brief    : Self-checking bench for cp0_exc_unit: vector table, directed
//             multi-cycle sequences and a randomized run against a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_exc_unit;

    localparam logic [31:0] c_VEC = 32'hBFC0_0380;
`ifdef CP0_TIMER_INT_EN
    localparam bit c_TIMER = 1'b1;
`else
    localparam bit c_TIMER = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_in_ds;
    logic [6:0]  mem_excp;
    logic [31:0] mem_badvaddr;
    logic        mem_eret;
    logic        mem_mtc0;
    logic [7:0]  mem_cp0_addr;
    logic [31:0] mem_wdata;
    logic        ex_mfc0;
    logic [7:0]  ex_cp0_addr;
    logic [5:0]  ext_int;
    logic [31:0] cp0_rdata;
    logic [32:0] CP0_to_ctrl_bus;
    logic        stallreq_for_cp0;

    int n_tests = 0;
    int n_fail  = 0;

    cp0_exc_unit dut (
        .clk              (clk),
        .resetn           (resetn),
        .mem_valid        (mem_valid),
        .mem_pc           (mem_pc),
        .mem_in_ds        (mem_in_ds),
        .mem_excp         (mem_excp),
        .mem_badvaddr     (mem_badvaddr),
        .mem_eret         (mem_eret),
        .mem_mtc0         (mem_mtc0),
        .mem_cp0_addr     (mem_cp0_addr),
        .mem_wdata        (mem_wdata),
        .ex_mfc0          (ex_mfc0),
        .ex_cp0_addr      (ex_cp0_addr),
        .ext_int          (ext_int),
        .cp0_rdata        (cp0_rdata),
        .CP0_to_ctrl_bus  (CP0_to_ctrl_bus),
        .stallreq_for_cp0 (stallreq_for_cp0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic idle();
        mem_valid    = 1'b0;
        mem_pc       = 32'd0;
        mem_in_ds    = 1'b0;
        mem_excp     = 7'd0;
        mem_badvaddr = 32'd0;
        mem_eret     = 1'b0;
        mem_mtc0     = 1'b0;
        mem_cp0_addr = 8'd0;
        mem_wdata    = 32'd0;
        ex_mfc0      = 1'b0;
        ex_cp0_addr  = 8'd0;
    endtask

    // All sequences start and end at a falling edge.
    task automatic do_reset();
        idle();
        ext_int = 6'd0;
        resetn  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic mtc0_op(input logic [7:0] a, input logic [31:0] d);
        idle();
        mem_valid    = 1'b1;
        mem_mtc0     = 1'b1;
        mem_cp0_addr = a;
        mem_wdata    = d;
        @(negedge clk);
        idle();
    endtask

    task automatic read_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        idle();
        ex_mfc0     = 1'b1;
        ex_cp0_addr = a;
        #1;
        check(name, {1'b0, cp0_rdata}, {1'b0, exp});
        @(negedge clk);
        idle();
    endtask

    // ---------------- reference model: CP0 as an array of words ----------------
    logic [31:0] m_reg [32];
    bit          m_tick;
    bit          m_armed;
    logic [4:0]  code_of [8] = '{5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05, 5'h00};

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_reg[12] = 32'h0040_0000;
        m_tick    = 1'b0;
        m_armed   = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
        if (a[2:0] != 3'd0) return 32'd0;
        case (a[7:3])
            5'd8, 5'd12, 5'd13, 5'd14: return m_reg[a[7:3]];
            5'd9, 5'd11:               return c_TIMER ? m_reg[a[7:3]] : 32'd0;
            default:                   return 32'd0;
        endcase
    endfunction

    function automatic bit m_pending();
        logic [31:0] st;
        logic [31:0] cs;
        st = m_reg[12];
        cs = m_reg[13];
        return st[0] && !st[1] && ((cs[15:8] & st[15:8]) != 8'd0);
    endfunction

    // -1: nothing, 7: interrupt, 0..6: first flag set
    function automatic int m_exc_idx(input logic [6:0] excp, input bit intp);
        if (intp) return 7;
        for (int i = 0; i < 7; i++) if (excp[i]) return i;
        return -1;
    endfunction

    task automatic m_step(input bit take, input int idx);
        logic [31:0] cnt, cmp, st, cs, cnt_new;
        bit ti_old, ti_new;
        cnt     = m_reg[9];
        cmp     = m_reg[11];
        st      = m_reg[12];
        cs      = m_reg[13];
        ti_old  = cs[30];
        ti_new  = ti_old;
        cnt_new = m_tick ? cnt + 32'd1 : cnt;
        if (c_TIMER && cnt == cmp && (cmp != 32'd0 || m_armed)) ti_new = 1'b1;
        if (take) begin
            cs[6:2] = code_of[idx];
            if (!st[1]) begin
                m_reg[14] = mem_in_ds ? mem_pc - 32'd4 : mem_pc;
                cs[31]    = mem_in_ds;
            end
            st[1] = 1'b1;
            if (idx == 0) m_reg[8] = mem_pc;
            else if (idx == 5 || idx == 6) m_reg[8] = mem_badvaddr;
        end else if (mem_valid && mem_eret) begin
            st[1] = 1'b0;
        end else if (mem_valid && mem_mtc0 && mem_cp0_addr[2:0] == 3'd0) begin
            case (mem_cp0_addr[7:3])
                5'd12: st = (st & ~32'h0000_FF03) | (mem_wdata & 32'h0000_FF03);
                5'd13: cs[9:8] = mem_wdata[9:8];
                5'd14: m_reg[14] = mem_wdata;
                5'd9:  cnt_new = mem_wdata;
                5'd11: begin cmp = mem_wdata; m_armed = 1'b1; ti_new = 1'b0; end
                default: ;
            endcase
        end
        if (c_TIMER) begin
            m_reg[9]  = cnt_new;
            m_reg[11] = cmp;
        end
        cs[30]     = c_TIMER ? ti_new : 1'b0;
        cs[15:10]  = {ext_int[5] | ti_old, ext_int[4:0]};
        m_reg[12]  = st;
        m_reg[13]  = cs;
        m_tick     = !m_tick;
    endtask

    // ---------------- commit vector table ----------------
    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        ds;
        logic [6:0]  excp;
        logic [31:0] badv;
        logic        eret;
        logic [32:0] exp_bus;
        logic [7:0]  rd_addr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [15];

    logic [7:0] addr_pool [8] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h61, 8'h78};

    initial begin
        bit          found;
        int          idx;
        bit          take;
        logic [32:0] exp_bus;
        logic        exp_stall;
        int          r;

        tbl[0]  = '{1'b1, 32'hBFC0_0100, 1'b0, 7'b0001000, 32'h0,         1'b0, {1'b1, c_VEC},        8'h70, 32'hBFC0_0100};
        tbl[1]  = '{1'b1, 32'h0,         1'b0, 7'b0000000, 32'h0,         1'b1, {1'b1, 32'hBFC0_0100}, 8'h60, 32'h0040_0000};
        tbl[2]  = '{1'b1, 32'hBFC0_0204, 1'b1, 7'b1000000, 32'h3,         1'b0, {1'b1, c_VEC},        8'h40, 32'h0000_0003};
        tbl[3]  = '{1'b0, 32'h0,         1'b0, 7'b0000000, 32'h0,         1'b0, 33'd0,                8'h70, 32'hBFC0_0200};
        tbl[4]  = '{1'b0, 32'h0,         1'b0, 7'b0000000, 32'h0,         1'b0, 33'd0,                8'h68, 32'h8000_0014};
        tbl[5]  = '{1'b0, 32'h0,         1'b0, 7'b0000000, 32'h0,         1'b0, 33'd0,                8'h60, 32'h0040_0002};
        tbl[6]  = '{1'b1, 32'h1234_5678, 1'b0, 7'b0000010, 32'h0,         1'b0, {1'b1, c_VEC},        8'h70, 32'hBFC0_0200};
        tbl[7]  = '{1'b0, 32'h0,         1'b0, 7'b0000000, 32'h0,         1'b0, 33'd0,                8'h68, 32'h8000_0028};
        tbl[8]  = '{1'b1, 32'h0,         1'b0, 7'b0000000, 32'h0,         1'b1, {1'b1, 32'hBFC0_0200}, 8'h60, 32'h0040_0000};
        tbl[9]  = '{1'b1, 32'h0000_0101, 1'b0, 7'b0100001, 32'hDEAD_BEEF, 1'b0, {1'b1, c_VEC},        8'h40, 32'h0000_0101};
        tbl[10] = '{1'b0, 32'h0,         1'b0, 7'b0000010, 32'h0,         1'b0, 33'd0,                8'h68, 32'h0000_0010};
        tbl[11] = '{1'b0, 32'h0,         1'b0, 7'b0000000, 32'h0,         1'b1, 33'd0,                8'h60, 32'h0040_0002};
        tbl[12] = '{1'b1, 32'h0,         1'b0, 7'b0000000, 32'h0,         1'b1, {1'b1, 32'h0000_0101}, 8'h60, 32'h0040_0000};
        tbl[13] = '{1'b1, 32'h0000_0400, 1'b0, 7'b0011100, 32'h0,         1'b0, {1'b1, c_VEC},        8'h68, 32'h0000_0030};
        tbl[14] = '{1'b1, 32'h0000_0800, 1'b0, 7'b1100000, 32'h0000_0777, 1'b0, {1'b1, c_VEC},        8'h40, 32'h0000_0777};

        // ---- reset: outputs held low even with an exception and hazard presented
        @(negedge clk);
        idle();
        ext_int      = 6'd0;
        resetn       = 1'b0;
        mem_valid    = 1'b1;
        mem_excp     = 7'b0001000;
        mem_mtc0     = 1'b1;
        mem_cp0_addr = 8'h70;
        ex_mfc0      = 1'b1;
        ex_cp0_addr  = 8'h70;
        @(negedge clk);
        #1;
        check("reset_bus", CP0_to_ctrl_bus, 33'd0);
        check("reset_stall", {32'd0, stallreq_for_cp0}, 33'd0);
        @(negedge clk);
        idle();
        resetn = 1'b1;
        read_chk("reset_status", 8'h60, 32'h0040_0000);
        read_chk("reset_cause", 8'h68, 32'h0000_0000);
        read_chk("reset_epc", 8'h70, 32'h0000_0000);
        #1;
        check("reset_bus_idle", CP0_to_ctrl_bus, 33'd0);

        // ---- table-driven commits
        for (int i = 0; i < 15; i++) begin
            idle();
            mem_valid    = tbl[i].valid;
            mem_pc       = tbl[i].pc;
            mem_in_ds    = tbl[i].ds;
            mem_excp     = tbl[i].excp;
            mem_badvaddr = tbl[i].badv;
            mem_eret     = tbl[i].eret;
            #1;
            check($sformatf("tbl%0d_bus", i), CP0_to_ctrl_bus, tbl[i].exp_bus);
            @(negedge clk);
            read_chk($sformatf("tbl%0d_rd", i), tbl[i].rd_addr, tbl[i].exp_rd);
        end

        // ---- hazard: MTC0 EPC in MEM with MFC0 EPC in EX, then ERET to it
        do_reset();
        mem_valid = 1'b1;
        mem_pc    = 32'hBFC0_0100;
        mem_excp  = 7'b0001000;
        @(negedge clk);
        idle();
        mem_valid    = 1'b1;
        mem_mtc0     = 1'b1;
        mem_cp0_addr = 8'h70;
        mem_wdata    = 32'h8000_1000;
        ex_mfc0      = 1'b1;
        ex_cp0_addr  = 8'h70;
        #1;
        check("haz_stall", {32'd0, stallreq_for_cp0}, 33'd1);
        check("haz_bus", CP0_to_ctrl_bus, 33'd0);
        @(negedge clk);
        idle();
        ex_mfc0     = 1'b1;
        ex_cp0_addr = 8'h70;
        #1;
        check("haz_stall_release", {32'd0, stallreq_for_cp0}, 33'd0);
        check("haz_rdata", {1'b0, cp0_rdata}, {1'b0, 32'h8000_1000});
        @(negedge clk);
        idle();
        mem_valid = 1'b1;
        mem_eret  = 1'b1;
        #1;
        check("eret_bus", CP0_to_ctrl_bus, {1'b1, 32'h8000_1000});
        @(negedge clk);
        read_chk("eret_exl_clear", 8'h60, 32'h0040_0000);

        // same hazard but the MTC0 itself excepts: no stall, write suppressed
        mem_valid    = 1'b1;
        mem_pc       = 32'h2222_0000;
        mem_excp     = 7'b0000010;
        mem_mtc0     = 1'b1;
        mem_cp0_addr = 8'h70;
        mem_wdata    = 32'h1111_0000;
        ex_mfc0      = 1'b1;
        ex_cp0_addr  = 8'h70;
        #1;
        check("haz_exc_stall", {32'd0, stallreq_for_cp0}, 33'd0);
        check("haz_exc_bus", CP0_to_ctrl_bus, {1'b1, c_VEC});
        @(negedge clk);
        read_chk("haz_exc_epc", 8'h70, 32'h2222_0000);

        // ---- external interrupt on IP7, taken only on a valid instruction
        do_reset();
        mtc0_op(8'h60, 32'h0000_8001);
        ext_int = 6'b100000;
        #1;
        check("int_bubble_bus", CP0_to_ctrl_bus, 33'd0);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_pc    = 32'h0000_3000;
        #1;
        check("int_bus", CP0_to_ctrl_bus, {1'b1, c_VEC});
        @(negedge clk);
        read_chk("int_cause", 8'h68, 32'h0000_8000);
        read_chk("int_epc", 8'h70, 32'h0000_3000);
        ext_int = 6'd0;

`ifdef CP0_TIMER_INT_EN
        // ---- timer interrupt
        do_reset();
        mtc0_op(8'h58, 32'd10);
        mtc0_op(8'h48, 32'd0);
        mtc0_op(8'h60, 32'h0000_8001);
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            ex_mfc0     = 1'b1;
            ex_cp0_addr = 8'h68;
            #1;
            if (cp0_rdata[30]) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("timer_ti_set", {32'd0, found}, 33'd1);
        @(negedge clk);
        idle();
        mem_valid = 1'b1;
        mem_pc    = 32'h0000_5000;
        #1;
        check("timer_int_bus", CP0_to_ctrl_bus, {1'b1, c_VEC});
        @(negedge clk);
        idle();
        ex_mfc0     = 1'b1;
        ex_cp0_addr = 8'h68;
        #1;
        check("timer_cause", {27'd0, cp0_rdata[30], cp0_rdata[6:2]}, {27'd0, 1'b1, 5'h00});
        @(negedge clk);
        mtc0_op(8'h58, 32'd100);
        ex_mfc0     = 1'b1;
        ex_cp0_addr = 8'h68;
        #1;
        check("timer_ti_clear", {32'd0, cp0_rdata[30]}, 33'd0);
        @(negedge clk);
        idle();
`else
        // ---- timer absent: Count/Compare read 0 and ignore writes
        do_reset();
        mtc0_op(8'h48, 32'd5);
        mtc0_op(8'h58, 32'd7);
        read_chk("count_absent", 8'h48, 32'd0);
        read_chk("compare_absent", 8'h58, 32'd0);
`endif

        // ---- randomized run against the model
        do_reset();
        m_reset();
        for (int n = 0; n < 600; n++) begin
            mem_valid    = ($urandom_range(0, 3) != 0);
            mem_pc       = $urandom & 32'hFFFF_FFFC;
            mem_in_ds    = 1'($urandom_range(0, 1));
            mem_excp     = ($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'd0;
            mem_badvaddr = $urandom;
            r            = int'($urandom_range(0, 7));
            mem_eret     = (r == 0);
            mem_mtc0     = (r >= 5);
            mem_cp0_addr = addr_pool[$urandom_range(0, 7)];
            mem_wdata    = $urandom;
            ex_mfc0      = 1'($urandom_range(0, 1));
            ex_cp0_addr  = ($urandom_range(0, 1) != 0) ? mem_cp0_addr : addr_pool[$urandom_range(0, 7)];
            ext_int      = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            #1;
            idx  = m_exc_idx(mem_excp, m_pending());
            take = mem_valid && (idx >= 0);
            if (take)                       exp_bus = {1'b1, c_VEC};
            else if (mem_valid && mem_eret) exp_bus = {1'b1, m_reg[14]};
            else                            exp_bus = 33'd0;
            exp_stall = ex_mfc0 && mem_valid && mem_mtc0 && (ex_cp0_addr == mem_cp0_addr) && !exp_bus[32];
            check("rnd_bus", CP0_to_ctrl_bus, exp_bus);
            check("rnd_stall", {32'd0, stallreq_for_cp0}, {32'd0, exp_stall});
            check("rnd_rdata", {1'b0, cp0_rdata}, {1'b0, m_read(ex_cp0_addr)});
            m_step(take, idx);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
